// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard unit: register-address constants,
// mul/div timer state encoding and the $0-aware register-match helper.
package pipeline_hazard_unit_pkg;

  localparam int          REG_AW   = 5;
  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam int          MD_CNT_W = 6;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // A destination matches a source only when the source is actually read and
  // the destination is not $0 (writes to $0 are discarded, so no dependency).
  function automatic logic reg_hit(input logic [REG_AW-1:0] rd,
                                   input logic [REG_AW-1:0] src,
                                   input logic              src_en);
    return src_en && (rd != REG_ZERO) && (rd == src);
  endfunction

endpackage

// File: rtl/pipeline_hazard_unit_muldiv_busy_timer.sv
// Tracks how long the multi-cycle mul/div unit stays busy after a launch.
// Busy is high for exactly MULDIV_LAT cycles, starting the cycle after start_i.
module muldiv_busy_timer
  import pipeline_hazard_unit_pkg::*;
#(
  parameter int MULDIV_LAT = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  output logic       busy_o,
  output logic       state_o,
  output logic [5:0] md_cnt_o
);

  localparam logic [MD_CNT_W-1:0] LAT = MD_CNT_W'(MULDIV_LAT);

  md_state_e           state_q, state_d;
  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= MD_IDLE;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          state_d  = MD_RUN;
          md_cnt_d = LAT;
        end
      end
      MD_RUN: begin
        // A start while running is illegal upstream; restarting the window
        // keeps HI/LO consumers stalled until the newest operation finishes.
        if (start_i) begin
          md_cnt_d = LAT;
        end else if (md_cnt_q == MD_CNT_W'(1)) begin
          state_d  = MD_IDLE;
          md_cnt_d = '0;
        end else begin
          md_cnt_d = md_cnt_q - MD_CNT_W'(1);
        end
      end
      default: begin
        state_d  = MD_IDLE;
        md_cnt_d = '0;
      end
    endcase
  end

  assign busy_o   = (state_q == MD_RUN);
  assign state_o  = state_q;
  assign md_cnt_o = md_cnt_q;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Stall/flush controller for the 5-stage pipeline: detects hazards bypassing
// cannot cover, drives PC/IFID enables and flushes, and counts stall cycles.
module pipeline_hazard_unit
  import pipeline_hazard_unit_pkg::*;
#(
  parameter int MULDIV_LAT = 32,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             ID_UseRt,
  input  logic             ID_Branch,
  input  logic             ID_BrTaken,
  input  logic             ID_MDUse,
  input  logic             IDEX_MemRd,
  input  logic             IDEX_RegWr,
  input  logic [4:0]       IDEX_Rd,
  input  logic             EXMEM_MemRd,
  input  logic [4:0]       EXMEM_Rd,
  input  logic             EX_MDStart,
  output logic             PC_Wr,
  output logic             IFID_Wr,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             MD_Busy,
  output logic [CNT_W-1:0] StallCnt
);

  logic             md_busy;
  logic             md_state;
  logic [5:0]       md_cnt;
  logic             src_b_en;
  logic             hit_ex;
  logic             hit_mem;
  logic             load_use;
  logic             br_ex;
  logic             br_mem;
  logic             md_haz;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  muldiv_busy_timer #(
    .MULDIV_LAT (MULDIV_LAT)
  ) u_md_timer (
    .clk      (clk),
    .reset    (reset),
    .start_i  (EX_MDStart),
    .busy_o   (md_busy),
    .state_o  (md_state),
    .md_cnt_o (md_cnt)
  );

  // Branches compare both operands in ID, so rt is a live source for them
  // even when the instruction format would not otherwise read it.
  assign src_b_en = ID_UseRt | ID_Branch;

  assign hit_ex  = reg_hit(IDEX_Rd,  IFID_Rs, 1'b1) | reg_hit(IDEX_Rd,  IFID_Rt, src_b_en);
  assign hit_mem = reg_hit(EXMEM_Rd, IFID_Rs, 1'b1) | reg_hit(EXMEM_Rd, IFID_Rt, src_b_en);

  assign load_use = IDEX_MemRd & hit_ex;
  assign br_ex    = ID_Branch & IDEX_RegWr & hit_ex;
  assign br_mem   = ID_Branch & EXMEM_MemRd & hit_mem;
  assign md_haz   = ID_MDUse & (md_busy | EX_MDStart);
  assign stall    = load_use | br_ex | br_mem | md_haz;

  // A stalled branch has stale operands, so its taken flag must not flush IF/ID.
  always_comb begin
    PC_Wr      = 1'b1;
    IFID_Wr    = 1'b1;
    IFID_Flush = ID_BrTaken;
    IDEX_Flush = 1'b0;
    if (stall) begin
      PC_Wr      = 1'b0;
      IFID_Wr    = 1'b0;
      IFID_Flush = 1'b0;
      IDEX_Flush = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign MD_Busy  = md_busy;
  assign StallCnt = stall_cnt_q;

  always_comb begin
    assert (md_busy == (md_state == MD_RUN));
    assert ((md_cnt == 6'd0) || (md_state == MD_RUN));
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: combinational vector table plus multi-cycle
// sequences for the mul/div window, reset during RUN and counter saturation.
module tb_pipeline_hazard_unit;

  localparam int LAT = 4;
  localparam int CW  = 4;

  logic          clk;
  logic          reset;
  logic [4:0]    IFID_Rs, IFID_Rt, IDEX_Rd, EXMEM_Rd;
  logic          ID_UseRt, ID_Branch, ID_BrTaken, ID_MDUse;
  logic          IDEX_MemRd, IDEX_RegWr, EXMEM_MemRd, EX_MDStart;
  logic          PC_Wr, IFID_Wr, IFID_Flush, IDEX_Flush, MD_Busy;
  logic [CW-1:0] StallCnt;

  pipeline_hazard_unit #(
    .MULDIV_LAT (LAT),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .IFID_Rs     (IFID_Rs),
    .IFID_Rt     (IFID_Rt),
    .ID_UseRt    (ID_UseRt),
    .ID_Branch   (ID_Branch),
    .ID_BrTaken  (ID_BrTaken),
    .ID_MDUse    (ID_MDUse),
    .IDEX_MemRd  (IDEX_MemRd),
    .IDEX_RegWr  (IDEX_RegWr),
    .IDEX_Rd     (IDEX_Rd),
    .EXMEM_MemRd (EXMEM_MemRd),
    .EXMEM_Rd    (EXMEM_Rd),
    .EX_MDStart  (EX_MDStart),
    .PC_Wr       (PC_Wr),
    .IFID_Wr     (IFID_Wr),
    .IFID_Flush  (IFID_Flush),
    .IDEX_Flush  (IDEX_Flush),
    .MD_Busy     (MD_Busy),
    .StallCnt    (StallCnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word order: {PC_Wr, IFID_Wr, IFID_Flush, IDEX_Flush}
  localparam logic [3:0] NS  = 4'b1100;
  localparam logic [3:0] NSB = 4'b1110;
  localparam logic [3:0] ST  = 4'b0001;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rt;
    logic       branch;
    logic       taken;
    logic       md_use;
    logic       ex_memrd;
    logic       ex_regwr;
    logic [4:0] ex_rd;
    logic       mem_memrd;
    logic [4:0] mem_rd;
    logic [3:0] exp;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs[NVEC];

  int            checks = 0;
  int            errors = 0;
  logic [3:0]    exp_q[$];
  logic [CW-1:0] exp_cnt;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int rs, input int rt, input bit use_rt, input bit branch,
                              input bit taken, input bit md_use, input bit ex_memrd,
                              input bit ex_regwr, input int ex_rd, input bit mem_memrd,
                              input int mem_rd, input logic [3:0] exp);
    vec_t v;
    v.rs = 5'(rs);  v.rt = 5'(rt);  v.use_rt = use_rt;  v.branch = branch;
    v.taken = taken;  v.md_use = md_use;  v.ex_memrd = ex_memrd;  v.ex_regwr = ex_regwr;
    v.ex_rd = 5'(ex_rd);  v.mem_memrd = mem_memrd;  v.mem_rd = 5'(mem_rd);  v.exp = exp;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    IFID_Rs = '0; IFID_Rt = '0; ID_UseRt = 0; ID_Branch = 0; ID_BrTaken = 0; ID_MDUse = 0;
    IDEX_MemRd = 0; IDEX_RegWr = 0; IDEX_Rd = '0; EXMEM_MemRd = 0; EXMEM_Rd = '0;
    EX_MDStart = 0;
  endtask

  task automatic drive_vec(input vec_t v);
    IFID_Rs = v.rs; IFID_Rt = v.rt; ID_UseRt = v.use_rt; ID_Branch = v.branch;
    ID_BrTaken = v.taken; ID_MDUse = v.md_use; IDEX_MemRd = v.ex_memrd;
    IDEX_RegWr = v.ex_regwr; IDEX_Rd = v.ex_rd; EXMEM_MemRd = v.mem_memrd;
    EXMEM_Rd = v.mem_rd; EX_MDStart = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_cnt = '0;
  endtask

  // cycle k: EX_MDStart only in cycle 0, ID_MDUse held throughout
  task automatic md_cycle(input int k, input string tag);
    @(posedge clk);
    #1;
    EX_MDStart = (k == 0);
    ID_MDUse   = 1'b1;
    @(negedge clk);
    check($sformatf("%s_busy_c%0d", tag, k), 32'(MD_Busy), 32'(k >= 1 && k <= LAT));
    check($sformatf("%s_pcwr_c%0d", tag, k), 32'(PC_Wr),   32'(k > LAT));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vecs[0]  = mk( 0,  0, 0, 0, 0, 0, 0, 0,  0, 0,  0, NS );  // all zero
    vecs[1]  = mk( 8,  0, 0, 0, 0, 0, 1, 1,  8, 0,  0, ST );  // load-use on rs
    vecs[2]  = mk( 0,  0, 0, 0, 0, 0, 1, 1,  0, 0,  0, NS );  // $0 never hazards
    vecs[3]  = mk( 1,  5, 1, 0, 0, 0, 1, 1,  5, 0,  0, ST );  // load-use on rt
    vecs[4]  = mk( 1,  5, 0, 0, 0, 0, 1, 1,  5, 0,  0, NS );  // rt not read
    vecs[5]  = mk( 3,  9, 0, 1, 1, 0, 0, 1,  9, 0,  0, ST );  // branch vs EX, taken ignored
    vecs[6]  = mk( 3,  9, 0, 1, 1, 0, 0, 1, 10, 0,  0, NSB);  // branch resolves, flush
    vecs[7]  = mk( 4,  6, 0, 1, 0, 0, 0, 0,  0, 1,  4, ST );  // branch vs MEM load
    vecs[8]  = mk( 4,  6, 0, 1, 1, 0, 0, 0,  0, 0,  4, NSB);  // MEM not a load
    vecs[9]  = mk( 7,  0, 0, 0, 0, 0, 0, 1,  7, 0,  0, NS );  // ALU dep, bypassed
    vecs[10] = mk( 0,  0, 0, 1, 1, 0, 0, 1,  0, 0,  0, NSB);  // branch on $0
    vecs[11] = mk( 2,  3, 0, 0, 0, 1, 0, 0,  0, 0,  0, NS );  // HI/LO use, unit idle
    vecs[12] = mk( 4,  0, 0, 0, 0, 0, 0, 0,  0, 1,  4, NS );  // MEM load, no branch
    vecs[13] = mk(31,  2, 0, 0, 1, 0, 1, 1, 31, 0,  0, ST );  // stall masks taken
    vecs[14] = mk( 2, 12, 0, 1, 0, 0, 0, 0,  0, 1, 12, ST );  // branch rt vs MEM load
    vecs[15] = mk( 2, 12, 1, 0, 0, 0, 1, 0, 12, 1,  3, ST );  // load-use, no regwr
    drive_idle();
    reset   = 1'b0;
    exp_cnt = '0;
    #12;
    check("reset_busy", 32'(MD_Busy), 32'd0);
    check("reset_cnt",  32'(StallCnt), 32'd0);
    check("reset_ctl",  32'({PC_Wr, IFID_Wr, IFID_Flush, IDEX_Flush}), 32'(NS));
    do_reset();

    // mul/div window: busy cycles 1..LAT, stalls cycles 0..LAT
    for (int k = 0; k <= LAT + 2; k++) md_cycle(k, "md");
    check("md_stallcnt", 32'(StallCnt), 32'(LAT + 1));

    // reset while RUN with md_cnt == 2
    do_reset();
    for (int k = 0; k <= LAT - 1; k++) md_cycle(k, "mdrst");
    check("mdrst_cnt_before", 32'(StallCnt), 32'(LAT - 1));
    #1 reset = 1'b0;
    #1;
    check("mdrst_busy",  32'(MD_Busy),    32'd0);
    check("mdrst_cnt",   32'(StallCnt),   32'd0);
    check("mdrst_pcwr",  32'(PC_Wr),      32'd1);
    check("mdrst_flush", 32'(IDEX_Flush), 32'd0);
    #1 reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("mdrst_stay_idle", 32'(MD_Busy), 32'd0);
    end
    check("mdrst_cnt_after", 32'(StallCnt), 32'd0);

    // table of single-cycle vectors through the expected queue
    do_reset();
    for (int i = 0; i < NVEC; i++) begin
      logic [3:0] e;
      @(posedge clk);
      #1;
      drive_vec(vecs[i]);
      exp_q.push_back(vecs[i].exp);
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("vec%0d_ctl", i), 32'({PC_Wr, IFID_Wr, IFID_Flush, IDEX_Flush}), 32'(e));
      check($sformatf("vec%0d_cnt", i), 32'(StallCnt), 32'(exp_cnt));
      if (!e[3] && !(&exp_cnt)) exp_cnt = exp_cnt + 1'b1;
    end

    // saturation: 20 load-use stall cycles into a 4-bit counter
    do_reset();
    @(posedge clk);
    #1 drive_vec(vecs[1]);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("sat_mid", 32'(StallCnt), 32'd10);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("sat_full", 32'(StallCnt), 32'd15);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("sat_hold", 32'(StallCnt), 32'd15);
    check("sat_ctl", 32'({PC_Wr, IFID_Wr, IFID_Flush, IDEX_Flush}), 32'(ST));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
